reset_ctrl: RTL and testbench



---
 rtl/reset_ctrl_if.sv | 24 ++
 rtl/reset_ctrl.sv | 135 +++++++++++++
 tb/tb_reset_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/reset_ctrl_if.sv
// Request inputs and reset/status outputs of the system reset controller.
// The watchdog kick signal exists only when RESET_CTRL_WDOG_EN is defined.
interface reset_ctrl_if;
  logic       btn_i;
  logic       sw_rst_i;
`ifdef RESET_CTRL_WDOG_EN
  logic       wdog_kick_i;
`endif
  logic       rst;
  logic [1:0] rst_cause;
  logic [7:0] rst_count;

`ifdef RESET_CTRL_WDOG_EN
  modport slave  (input  btn_i, sw_rst_i, wdog_kick_i,
                  output rst, rst_cause, rst_count);
  modport master (output btn_i, sw_rst_i, wdog_kick_i,
                  input  rst, rst_cause, rst_count);
`else
  modport slave  (input  btn_i, sw_rst_i,
                  output rst, rst_cause, rst_count);
  modport master (output btn_i, sw_rst_i,
                  input  rst, rst_cause, rst_count);
`endif
endinterface

// File: rtl/reset_ctrl.sv
// System reset controller: async-assert / sync-release rst with a minimum hold width,
// debounced button, software request, cause latch and reset count. Watchdog: RESET_CTRL_WDOG_EN.
module reset_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYCLES     = 16,
`ifdef RESET_CTRL_WDOG_EN
  parameter int WDOG_CYCLES     = 65536,
`endif
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input logic         clk,
  input logic         rst_n,
  reset_ctrl_if.slave bus
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {S_HOLD, S_RUN} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_rel_sync;
  logic [SYNC_STAGES-1:0] r_btn_sync;
  logic                   r_btn_db;
  logic [DW-1:0]          r_db_cnt;
  logic [HW-1:0]          r_hold_cnt;
  logic                   r_rst;
  logic [1:0]             r_cause;
  logic [7:0]             r_count;

  logic       w_rel;
  logic       w_btn;
  logic       w_btn_req;
  logic       w_sw_req;
  logic       w_wdog_req;
  logic       w_req;
  logic [1:0] w_cause;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rel_sync <= '0;
      r_btn_sync <= '0;
    end else begin
      r_rel_sync <= {r_rel_sync[SYNC_STAGES-2:0], 1'b1};
      r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], bus.btn_i};
    end
  end

  assign w_rel = r_rel_sync[SYNC_STAGES-1];
  assign w_btn = r_btn_sync[SYNC_STAGES-1];

  // Only a debounced rising edge of the button is a request; release just ends the hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_db <= 1'b0;
      r_db_cnt <= '0;
    end else if (w_btn != r_btn_db) begin
      if (r_db_cnt == DB_LAST) begin
        r_btn_db <= w_btn;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DW'(1);
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  assign w_btn_req = w_btn && !r_btn_db && (r_db_cnt == DB_LAST);
  assign w_sw_req  = bus.sw_rst_i;

`ifdef RESET_CTRL_WDOG_EN
  localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  logic [WW-1:0] r_wdog_cnt;

  assign w_wdog_req = (r_state == S_RUN) && !bus.wdog_kick_i &&
                      (r_wdog_cnt == WW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog_cnt <= '0;
    end else if ((r_state != S_RUN) || bus.wdog_kick_i || w_wdog_req) begin
      r_wdog_cnt <= '0;
    end else begin
      r_wdog_cnt <= r_wdog_cnt + WW'(1);
    end
  end
`else
  assign w_wdog_req = 1'b0;
`endif

  assign w_req = w_btn_req || w_sw_req || w_wdog_req;

  always_comb begin
    w_cause = 2'b10;
    if (w_btn_req)       w_cause = 2'b01;
    else if (w_wdog_req) w_cause = 2'b11;
  end

  // Requests seen while already holding only restart the hold; they are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_HOLD;
      r_rst      <= 1'b1;
      r_cause    <= 2'b00;
      r_count    <= 8'd0;
      r_hold_cnt <= HOLD_LOAD;
    end else if (r_state == S_HOLD) begin
      if (w_req) begin
        r_hold_cnt <= HOLD_LOAD;
        r_cause    <= w_cause;
      end else if (!w_rel || r_btn_db) begin
        r_hold_cnt <= HOLD_LOAD;
      end else if (r_hold_cnt == '0) begin
        r_state <= S_RUN;
        r_rst   <= 1'b0;
      end else begin
        r_hold_cnt <= r_hold_cnt - HW'(1);
      end
    end else if (w_req) begin
      r_state    <= S_HOLD;
      r_rst      <= 1'b1;
      r_hold_cnt <= HOLD_LOAD;
      r_cause    <= w_cause;
      if (r_count != 8'hFF) r_count <= r_count + 8'd1;
    end
  end

  assign bus.rst       = r_rst;
  assign bus.rst_cause = r_cause;
  assign bus.rst_count = r_count;

endmodule

// File: tb/tb_reset_ctrl.sv
// Self-checking bench for reset_ctrl: edge-numbered behavioural model checked every cycle,
// plus hand-computed literal expectations. Covers the watchdog when RESET_CTRL_WDOG_EN is set.
module tb_reset_ctrl;
  localparam int S = 2;
  localparam int H = 16;
  localparam int D = 1000;
`ifdef RESET_CTRL_WDOG_EN
  localparam int W = 64;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  reset_ctrl_if bus ();

`ifdef RESET_CTRL_WDOG_EN
  reset_ctrl #(.SYNC_STAGES(S), .HOLD_CYCLES(H), .WDOG_CYCLES(W), .DEBOUNCE_CYCLES(D))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
  reset_ctrl #(.SYNC_STAGES(S), .HOLD_CYCLES(H), .DEBOUNCE_CYCLES(D))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: edges numbered from the first edge after rst_n release.
  int       m_n     = 0;
  int       m_fall  = 1 << 30;
  bit       m_rst   = 1'b1;
  bit [1:0] m_cause = 2'b00;
  int       m_count = 0;
  bit       m_db    = 1'b0;
  bit       hist [0:16383];
`ifdef RESET_CTRL_WDOG_EN
  int       m_wd_base = 0;
`endif

  function automatic bit syncd(int m);
    return (m - S >= 1) ? hist[m - S] : 1'b0;
  endfunction

  initial forever begin
    bit rst_old, db_old, flip, btn_acc, wd, sw;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_n = 0; m_fall = 1 << 30; m_rst = 1'b1; m_cause = 2'b00; m_count = 0; m_db = 1'b0;
`ifdef RESET_CTRL_WDOG_EN
      m_wd_base = 0;
`endif
    end else begin
      m_n++;
      if (m_n < 16384) hist[m_n] = bus.btn_i;
      rst_old = m_rst;
      db_old  = m_db;
      btn_acc = 1'b0;
      // A level is accepted once the synchronised input disagreed for D edges running.
      if (m_n >= D) begin
        flip = 1'b1;
        for (int j = 0; j < D; j++) begin
          if (syncd(m_n - j) == m_db) begin
            flip = 1'b0;
            break;
          end
        end
        if (flip) begin
          m_db    = !m_db;
          btn_acc = m_db;
        end
      end
      sw = bus.sw_rst_i;
      wd = 1'b0;
`ifdef RESET_CTRL_WDOG_EN
      wd = !rst_old && !bus.wdog_kick_i && (m_n - m_wd_base == W);
      if (!rst_old && bus.wdog_kick_i) m_wd_base = m_n;
`endif
      if (btn_acc || wd || sw) begin
        if (!rst_old && m_count < 255) m_count++;
        m_cause = btn_acc ? 2'b01 : (wd ? 2'b11 : 2'b10);
        m_fall  = m_n + H;
      end else if (rst_old && (m_n <= S || db_old)) begin
        m_fall = m_n + H;
      end
      m_rst = (m_n < m_fall);
`ifdef RESET_CTRL_WDOG_EN
      if (rst_old && !m_rst) m_wd_base = m_n;
`endif
    end
  end

  initial forever begin
    @(negedge clk);
    n_checks++;
    if (bus.rst !== m_rst || bus.rst_cause !== m_cause || bus.rst_count !== 8'(m_count)) begin
      n_fail++;
      $display("FAIL model edge=%0d rst got=%b want=%b cause got=%0d want=%0d count got=%0d want=%0d",
               m_n, bus.rst, m_rst, bus.rst_cause, m_cause, bus.rst_count, m_count);
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0d want=%0d", nm, m_n, act, exp);
    end
  endtask

  task automatic wait_edge(int k);
    while (m_n < k) @(negedge clk);
  endtask

  task automatic sw_at(int k);
    wait_edge(k - 1);
    bus.sw_rst_i = 1'b1;
    wait_edge(k);
    bus.sw_rst_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout edge=%0d", m_n);
    $fatal(1, "timeout");
  end

  initial begin
    bus.btn_i    = 1'b0;
    bus.sw_rst_i = 1'b0;
`ifdef RESET_CTRL_WDOG_EN
    bus.wdog_kick_i = 1'b1;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("por_rst", int'(bus.rst), 1);
    chk("por_cause", int'(bus.rst_cause), 0);
    chk("por_count", int'(bus.rst_count), 0);
    rst_n = 1'b1;
    wait_edge(17); chk("por_high_e17", int'(bus.rst), 1);
    wait_edge(18); chk("por_fall_e18", int'(bus.rst), 0);

    sw_at(100);
    chk("sw_rise_e100", int'(bus.rst), 1);
    chk("sw_cause", int'(bus.rst_cause), 2);
    chk("sw_count", int'(bus.rst_count), 1);
    wait_edge(115); chk("sw_high_e115", int'(bus.rst), 1);
    wait_edge(116); chk("sw_fall_e116", int'(bus.rst), 0);

    sw_at(200);
    sw_at(208);
    wait_edge(223); chk("hold_ext_e223", int'(bus.rst), 1);
    wait_edge(224); chk("hold_ext_fall_e224", int'(bus.rst), 0);
    chk("hold_ext_count", int'(bus.rst_count), 2);

    wait_edge(300); bus.btn_i = 1'b1;
    wait_edge(800); bus.btn_i = 1'b0;
    wait_edge(2000);
    chk("glitch_rst", int'(bus.rst), 0);
    chk("glitch_count", int'(bus.rst_count), 2);

    wait_edge(2100); bus.btn_i = 1'b1;
    wait_edge(3101); chk("btn_pre_e3101", int'(bus.rst), 0);
    wait_edge(3102); chk("btn_rise_e3102", int'(bus.rst), 1);
    chk("btn_cause", int'(bus.rst_cause), 1);
    chk("btn_count", int'(bus.rst_count), 3);
    wait_edge(5100); bus.btn_i = 1'b0;
    wait_edge(6117); chk("btn_held_e6117", int'(bus.rst), 1);
    wait_edge(6118); chk("btn_fall_e6118", int'(bus.rst), 0);

    wait_edge(7000); bus.btn_i = 1'b1;
    sw_at(8002);
    chk("simul_rst", int'(bus.rst), 1);
    chk("simul_cause", int'(bus.rst_cause), 1);
    chk("simul_count", int'(bus.rst_count), 4);
    wait_edge(8100); bus.btn_i = 1'b0;
    wait_edge(9118); chk("simul_fall_e9118", int'(bus.rst), 0);

    sw_at(9500);
    wait_edge(9505);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", int'(bus.rst), 1);
    chk("async_cause", int'(bus.rst_cause), 0);
    chk("async_count", int'(bus.rst_count), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_edge(17); chk("rerel_high_e17", int'(bus.rst), 1);
    wait_edge(18); chk("rerel_fall_e18", int'(bus.rst), 0);

`ifdef RESET_CTRL_WDOG_EN
    wait_edge(30); bus.wdog_kick_i = 1'b0;
    wait_edge(93); chk("wdog_pre_e93", int'(bus.rst), 0);
    wait_edge(94); chk("wdog_rise_e94", int'(bus.rst), 1);
    chk("wdog_cause", int'(bus.rst_cause), 3);
    chk("wdog_count", int'(bus.rst_count), 1);
    for (int k = 150; k <= 400; k += 50) begin
      wait_edge(k - 1); bus.wdog_kick_i = 1'b1;
      wait_edge(k);     bus.wdog_kick_i = 1'b0;
    end
    wait_edge(440);
    chk("wdog_kicked_rst", int'(bus.rst), 0);
    chk("wdog_kicked_count", int'(bus.rst_count), 1);
    bus.wdog_kick_i = 1'b1;
`endif

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
